// File: rtl/bus_region_decoder_pkg.sv
// rtl/bus_region_decoder_pkg.sv - shared types and helpers for the bus region decoder
package bus_region_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int WAIT_W = 4;

    // A single-region map still needs a 1-bit index register.
    function automatic int idx_width(input int regions);
        return (regions > 1) ? $clog2(regions) : 1;
    endfunction

endpackage

// File: rtl/bus_region_match.sv
// rtl/bus_region_match.sv - base/mask address compare with lowest-index priority
module bus_region_match
    import bus_region_decoder_pkg::*;
#(
    parameter int                          REGIONS     = 8,
    parameter int                          ADDR_W      = 16,
    parameter int                          IDX_W       = 3,
    parameter logic [REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [REGIONS*ADDR_W-1:0]   REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if ((i_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// rtl/bus_region_decoder.sv - memory-map decoder and access sequencer for N slave regions
module bus_region_decoder
    import bus_region_decoder_pkg::*;
#(
    parameter int                          REGIONS       = 8,
    parameter int                          ADDR_W        = 16,
    parameter int                          DATA_W        = 8,
    parameter logic [REGIONS*ADDR_W-1:0]   REGION_BASE   = {16'h3800, 16'h3000, 16'h2800, 16'h2000,
                                                            16'h1800, 16'h1000, 16'h0800, 16'h0000},
    parameter logic [REGIONS*ADDR_W-1:0]   REGION_MASK   = {8{16'hF800}},
    parameter logic [REGIONS*4-1:0]        REGION_WAIT   = '0,
    parameter logic [DATA_W-1:0]           UNMAPPED_DATA = 8'h00
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [ADDR_W-1:0]         cpuAddr,
    input  logic [DATA_W-1:0]         cpuDataWrite,
    input  logic                      cpuWrite,
    input  logic                      cpuStrobe,
    output logic [DATA_W-1:0]         cpuDataRead,
    output logic                      cpuReady,
    output logic                      busError,
    output logic                      overrun,
    output logic [ADDR_W-1:0]         devAddr,
    output logic [DATA_W-1:0]         devDataWrite,
    output logic                      devWrite,
    output logic [REGIONS-1:0]        devStrobe,
    input  logic [REGIONS*DATA_W-1:0] devDataRead
);

    localparam int IDX_W = idx_width(REGIONS);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [REGIONS-1:0]  r_dev_strobe;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_bus_error;
    logic                r_overrun;

    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic [REGIONS-1:0]  w_idx_onehot;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic [WAIT_W-1:0]   w_sel_wait;

    bus_region_match #(
        .REGIONS     (REGIONS),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .i_addr (cpuAddr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_idx_onehot = REGIONS'(1) << w_idx;
    assign w_sel_rdata  = devDataRead[int'(r_sel)*DATA_W +: DATA_W];
    assign w_sel_wait   = REGION_WAIT[int'(r_sel)*WAIT_W +: WAIT_W];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_dev_strobe <= '0;
            r_rdata      <= '0;
            r_ready      <= 1'b0;
            r_bus_error  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dev_strobe <= '0;
            r_ready      <= 1'b0;
            r_bus_error  <= 1'b0;
            if (cpuStrobe && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cpuStrobe) begin
                        r_addr  <= cpuAddr;
                        r_wdata <= cpuDataWrite;
                        r_write <= cpuWrite;
                        r_sel   <= w_idx;
                        if (w_hit) begin
                            r_dev_strobe <= w_idx_onehot;
                            r_state      <= ST_STROBE;
                        end else begin
                            // Unmapped: complete next cycle with an error, no device strobe.
                            if (!cpuWrite) begin
                                r_rdata <= UNMAPPED_DATA;
                            end
                            r_ready     <= 1'b1;
                            r_bus_error <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_STROBE: begin
                    r_cnt   <= w_sel_wait;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_write) begin
                            r_rdata <= w_sel_rdata;
                        end
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpuDataRead  = r_rdata;
    assign cpuReady     = r_ready;
    assign busError     = r_bus_error;
    assign overrun      = r_overrun;
    assign devAddr      = r_addr;
    assign devDataWrite = r_wdata;
    assign devWrite     = r_write;
    assign devStrobe    = r_dev_strobe;

endmodule

// File: tb/tb_bus_region_decoder.sv
// tb/tb_bus_region_decoder.sv - directed self-checking bench for bus_region_decoder
module tb_bus_region_decoder;

    localparam int REGIONS = 8;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    // Region 2 overlaps region 1 at 0x09xx; region 3 exercises the longest wait.
    localparam logic [REGIONS*ADDR_W-1:0] BASE = {16'hE000, 16'h3000, 16'h2000, 16'h1800,
                                                  16'h1000, 16'h0900, 16'h0800, 16'h0000};
    localparam logic [REGIONS*ADDR_W-1:0] MASK = {16'hF000, 16'hF000, 16'hF800, 16'hF800,
                                                  16'hF800, 16'hFF00, 16'hF800, 16'hF800};
    localparam logic [REGIONS*4-1:0]      WAIT = {4'd5, 4'd10, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0};
    localparam logic [DATA_W-1:0]         UNMAPPED = 8'hEE;

    logic                      clk = 1'b0;
    logic                      resetN = 1'b0;
    logic [ADDR_W-1:0]         cpuAddr = '0;
    logic [DATA_W-1:0]         cpuDataWrite = '0;
    logic                      cpuWrite = 1'b0;
    logic                      cpuStrobe = 1'b0;
    logic [DATA_W-1:0]         cpuDataRead;
    logic                      cpuReady;
    logic                      busError;
    logic                      overrun;
    logic [ADDR_W-1:0]         devAddr;
    logic [DATA_W-1:0]         devDataWrite;
    logic                      devWrite;
    logic [REGIONS-1:0]        devStrobe;
    logic [REGIONS*DATA_W-1:0] devDataRead;

    int checks = 0;
    int failures = 0;

    assign devDataRead = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5};

    always #5 clk = ~clk;

    bus_region_decoder #(
        .REGIONS       (REGIONS),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .REGION_BASE   (BASE),
        .REGION_MASK   (MASK),
        .REGION_WAIT   (WAIT),
        .UNMAPPED_DATA (UNMAPPED)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .cpuAddr      (cpuAddr),
        .cpuDataWrite (cpuDataWrite),
        .cpuWrite     (cpuWrite),
        .cpuStrobe    (cpuStrobe),
        .cpuDataRead  (cpuDataRead),
        .cpuReady     (cpuReady),
        .busError     (busError),
        .overrun      (overrun),
        .devAddr      (devAddr),
        .devDataWrite (devDataWrite),
        .devWrite     (devWrite),
        .devStrobe    (devStrobe),
        .devDataRead  (devDataRead)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Issues one strobe in cycle 0 and watches cycles 1..40 until cpuReady.
    task automatic access(input string tag, input logic [15:0] a, input logic w, input logic [7:0] wd,
                          input int exp_lat, input logic [7:0] exp_strb, input logic [7:0] exp_data,
                          input logic exp_err);
        int strb_cyc = -1;
        int rdy_cyc  = -1;
        int pulses   = 0;
        logic [7:0]  strb_or = '0;
        logic [7:0]  data_at = '0;
        logic        err_at  = 1'b0;
        logic [15:0] daddr   = '0;
        logic [7:0]  dwd     = '0;
        logic        dw      = 1'b0;
        @(posedge clk); #1;
        cpuAddr = a; cpuWrite = w; cpuDataWrite = wd; cpuStrobe = 1'b1;
        @(posedge clk); #1;
        cpuStrobe = 1'b0;
        for (int k = 1; k <= 40 && rdy_cyc < 0; k++) begin
            @(negedge clk);
            if (devStrobe != '0) begin
                pulses++;
                strb_or |= devStrobe;
                if (strb_cyc < 0) begin
                    strb_cyc = k; daddr = devAddr; dwd = devDataWrite; dw = devWrite;
                end
            end
            if (cpuReady) begin
                rdy_cyc = k; data_at = cpuDataRead; err_at = busError;
            end
        end
        check_eq({tag, "_latency"}, rdy_cyc, exp_lat);
        check_eq({tag, "_strobe"}, {24'h0, strb_or}, {24'h0, exp_strb});
        check_eq({tag, "_pulses"}, pulses, (exp_strb != '0) ? 1 : 0);
        check_eq({tag, "_data"}, {24'h0, data_at}, {24'h0, exp_data});
        check_eq({tag, "_err"}, {31'h0, err_at}, {31'h0, exp_err});
        if (exp_strb != '0) begin
            check_eq({tag, "_strb_cyc"}, strb_cyc, 1);
            check_eq({tag, "_devaddr"}, {16'h0, daddr}, {16'h0, a});
            check_eq({tag, "_devwrite"}, {31'h0, dw}, {31'h0, w});
            if (w) check_eq({tag, "_devwdata"}, {24'h0, dwd}, {24'h0, wd});
        end
    endtask

    initial begin
        int pulses;
        int readies;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {31'h0, cpuReady}, 0);
        check_eq("rst_strobe", {24'h0, devStrobe}, 0);
        check_eq("rst_rdata", {24'h0, cpuDataRead}, 0);
        check_eq("rst_overrun", {31'h0, overrun}, 0);
        check_eq("rst_devaddr", {16'h0, devAddr}, 0);
        @(posedge clk); #1;
        resetN = 1'b1;

        access("rd_r0",     16'h0123, 1'b0, 8'h00, 3,  8'h01, 8'hA5, 1'b0);
        access("rd_r7",     16'hE123, 1'b0, 8'h00, 8,  8'h80, 8'h77, 1'b0);
        access("wr_r7",     16'hE010, 1'b1, 8'h5A, 8,  8'h80, 8'h77, 1'b0);
        access("rd_unmap",  16'h8000, 1'b0, 8'h00, 1,  8'h00, UNMAPPED, 1'b1);
        access("overlap",   16'h0900, 1'b0, 8'h00, 3,  8'h02, 8'h11, 1'b0);
        access("rd_w15",    16'h1000, 1'b0, 8'h00, 18, 8'h08, 8'h33, 1'b0);
        access("wr_unmap",  16'hF000, 1'b1, 8'h12, 1,  8'h00, 8'h33, 1'b1);
        check_eq("no_overrun", {31'h0, overrun}, 0);

        // Second strobe two cycles after the first.
        @(posedge clk); #1;
        cpuAddr = 16'h0123; cpuWrite = 1'b0; cpuStrobe = 1'b1;
        @(posedge clk); #1;
        cpuStrobe = 1'b0;
        @(negedge clk);
        check_eq("ovr_strobe1", {24'h0, devStrobe}, 8'h01);
        @(posedge clk); #1;
        cpuAddr = 16'h0800; cpuStrobe = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cpuStrobe = 1'b0;
        @(negedge clk);
        check_eq("ovr_ready", {31'h0, cpuReady}, 1);
        check_eq("ovr_data", {24'h0, cpuDataRead}, 8'hA5);
        check_eq("ovr_flag", {31'h0, overrun}, 1);
        pulses = 0;
        readies = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (devStrobe != '0) pulses++;
            if (cpuReady) readies++;
        end
        check_eq("ovr_no_strobe", pulses, 0);
        check_eq("ovr_no_ready", readies, 0);
        access("after_ovr", 16'h2000, 1'b0, 8'h00, 3, 8'h20, 8'h55, 1'b0);
        check_eq("ovr_sticky", {31'h0, overrun}, 1);

        // Reset in the middle of a 10-wait access.
        @(posedge clk); #1;
        cpuAddr = 16'h3000; cpuWrite = 1'b0; cpuStrobe = 1'b1;
        @(posedge clk); #1;
        cpuStrobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'h0, cpuReady}, 0);
        check_eq("mid_rst_strobe", {24'h0, devStrobe}, 0);
        check_eq("mid_rst_rdata", {24'h0, cpuDataRead}, 0);
        check_eq("mid_rst_overrun", {31'h0, overrun}, 0);
        check_eq("mid_rst_devaddr", {16'h0, devAddr}, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        readies = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (cpuReady) readies++;
        end
        check_eq("mid_rst_no_ready", readies, 0);
        access("after_rst", 16'h3000, 1'b0, 8'h00, 13, 8'h40, 8'h66, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
